mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage data-memory controller. Sits directly downstream of the EX/MEM pipeline register and consumes its control and data outputs.
- Runs a req/ack handshake to a variable-latency data memory and returns load data toward MEM/WB.
- Raises a stall while an access is outstanding. Also resolves the branch decision (pc_src) from the MEM-stage branch/zero flags.

Parameters:
- TIMEOUT_CYCLES, 16: max REQ cycles waiting for dmem_ack before abort; legal range 2..255.
- ALIGN_CHECK, 1: 1 = word-misaligned addresses fault without a bus request; 0 = addr[1:0] ignored.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- mem_read_mem  input  1  load in MEM stage
- mem_write_mem  input  1  store in MEM stage
- branch_mem  input  1  branch in MEM stage
- zero_mem  input  1  ALU zero flag from EX/MEM
- alu_result_mem  input  32  effective byte address
- read_data2_mem  input  32  store data (already forwarded)
- dmem_req  output  1  bus request, registered
- dmem_we  output  1  1 = write, registered
- dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}, registered
- dmem_wdata  output  32  store data, registered
- dmem_ack  input  1  memory completion, single-cycle pulse
- dmem_rdata  input  32  read data, valid with dmem_ack
- mem_read_data  output  32  load result to MEM/WB, registered
- mem_fault  output  1  access faulted (misaligned/timeout), valid in DONE
- stall_mem  output  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- pc_src  output  1  branch taken = branch_mem & zero_mem, combinational

Behaviour:
- Reset (async, immediate): state=IDLE, timeout counter=0. dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_read_data and mem_fault all 0. stall_mem=0 while reset is high.
- access = mem_read_mem | mem_write_mem. If both are set: treated as a write and mem_fault=1 in DONE; the write is still performed.
- States: IDLE, REQ, DONE.
- IDLE, access=0: stay; stall_mem=0.
- IDLE, access=1 and misaligned (ALIGN_CHECK=1, addr[1:0]!=0):
  - stall_mem=1; next=DONE; no request issued.
  - mem_fault<=1, mem_read_data<=0.
- IDLE, access=1 and aligned:
  - stall_mem=1; next=REQ.
  - On the same edge, latch dmem_addr/dmem_wdata/dmem_we and set dmem_req<=1; clear the counter.
- REQ:
  - stall_mem=1.
  - dmem_req, addr, we and wdata are held stable until the ack cycle.
  - Counter increments each cycle without ack.
- REQ with dmem_ack:
  - Capture mem_read_data<=dmem_rdata for a read, or 0 for a write.
  - mem_fault<=0, dmem_req<=0, next=DONE.
- REQ, counter reaches TIMEOUT_CYCLES-1 without ack: dmem_req<=0, mem_fault<=1, mem_read_data<=0, next=DONE.
  - If ack coincides with that cycle, ack wins (no fault).
- dmem_ack while in IDLE or DONE is ignored.
- DONE:
  - stall_mem=0, so the pipeline advances on this edge.
  - mem_read_data and mem_fault are valid for MEM/WB capture.
  - next=IDLE. mem_fault clears to 0 on leaving DONE; mem_read_data holds until the next capture.
- Latency: an aligned access with ack in the first REQ cycle occupies MEM for 3 cycles (IDLE, REQ, DONE). Each extra ack wait adds 1 cycle. A misaligned access takes 2 cycles.
- Back-to-back accesses: the next instruction is evaluated in IDLE after DONE; no access is issued twice.
- pc_src is pure combinational and independent of state. Branches never stall.
- Reset mid-REQ: dmem_req drops asynchronously and the access is abandoned; the memory must tolerate an un-acked request being withdrawn.

Test Plan:
- Load addr 0x0000_0010, ack after 1 REQ cycle with rdata 0xCAFE_F00D -> dmem_req high 1 cycle, dmem_we=0, stall_mem 1,1,0; mem_read_data=0xCAFE_F00D in DONE; mem_fault=0.
- Store addr 0x0000_0020, wdata 0x1234_5678, ack after 4 cycles -> dmem_we=1; addr/wdata stable all 4 REQ cycles; stall_mem high 5 cycles then 0 in DONE.
- Load addr 0x0000_0013 with ALIGN_CHECK=1 -> dmem_req never asserts; stall 1 cycle; DONE with mem_fault=1, mem_read_data=0.
- Load with no ack, TIMEOUT_CYCLES=16 -> dmem_req high exactly 16 cycles then drops; mem_fault=1 in DONE; a late ack 2 cycles later is ignored.
- Two consecutive loads (0x40, 0x44), each acked immediately -> two distinct requests 3 cycles apart; second returns its own data; no duplicate request.
- Reset pulsed during REQ -> dmem_req, mem_fault and stall_mem are 0 before the next edge; after release, access=0 stays IDLE. Separately: branch_mem=1, zero_mem=1 -> pc_src=1 with stall_mem=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: req/ack handshake to a variable-latency dmem, load return, stall, branch resolve.
// Latency: aligned access = IDLE + N REQ cycles (N = ack wait, >=1) + DONE; misaligned access = IDLE + DONE.
// Backpressure: stall_mem holds the upstream pipeline while an access is pending; dmem_req held stable until ack or timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic        branch_mem,
  input  logic        zero_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] read_data2_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_read_data,
  output logic        mem_fault,
  output logic        stall_mem,
  output logic        pc_src
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Last counter value before giving up on the memory.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] state;
  logic [7:0] tmo_cnt;
  logic       rw_conflict;  // both read and write requested: performed as a write, reported as a fault
  logic       access;
  logic       misaligned;

  assign access     = mem_read_mem | mem_write_mem;
  assign misaligned = ALIGN_CHECK && (alu_result_mem[1:0] != 2'b00);

  // Stall while an access is being started or is outstanding; DONE releases the pipeline.
  assign stall_mem = !reset && (((state == IDLE) && access) || (state == REQ));

  // Branch decision is independent of the memory access and never stalls.
  assign pc_src = branch_mem & zero_mem;

  // Access sequencer: launch, wait for ack or timeout, present result for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= 8'd0;
      rw_conflict   <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      mem_read_data <= 32'd0;
      mem_fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              // Fault without touching the bus.
              mem_fault     <= 1'b1;
              mem_read_data <= 32'd0;
              state         <= DONE;
            end else begin
              dmem_req    <= 1'b1;
              dmem_we     <= mem_write_mem;
              dmem_addr   <= {alu_result_mem[31:2], 2'b00};
              dmem_wdata  <= read_data2_mem;
              rw_conflict <= mem_read_mem & mem_write_mem;
              tmo_cnt     <= 8'd0;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            // Ack wins even on the final timeout cycle.
            mem_read_data <= dmem_we ? 32'd0 : dmem_rdata;
            mem_fault     <= rw_conflict;
            dmem_req      <= 1'b0;
            state         <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_read_data <= 32'd0;
            mem_fault     <= 1'b1;
            dmem_req      <= 1'b0;
            state         <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          // Result was visible for one cycle; fault is a one-shot, read data holds.
          mem_fault <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses, scoreboard queues for bus requests and MEM results.
// Latency: checks stall cycle counts per access and request spacing.
// Backpressure: a bench memory acks after a programmed number of REQ cycles (0 = never).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_mem, mem_write_mem, branch_mem, zero_mem;
  logic [31:0] alu_result_mem, read_data2_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_read_data;
  logic        mem_fault, stall_mem, pc_src;

  logic        resp_ack, late_ack;
  int          ack_wait;
  logic [31:0] ack_data;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } req_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } res_exp_t;

  req_exp_t req_q[$];
  res_exp_t res_q[$];

  int cyc = 0;
  int last_rise = 0;
  int prev_rise = 0;

  assign dmem_ack = resp_ack | late_ack;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(16), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .branch_mem(branch_mem), .zero_mem(zero_mem),
    .alu_result_mem(alu_result_mem), .read_data2_mem(read_data2_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_read_data(mem_read_data), .mem_fault(mem_fault),
    .stall_mem(stall_mem), .pc_src(pc_src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bench memory: ack in the ack_wait-th REQ cycle, single-cycle pulse.
  initial begin
    int rcnt;
    rcnt = 0;
    resp_ack = 1'b0;
    dmem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_req && !reset) begin
        rcnt++;
        if (ack_wait > 0 && rcnt == ack_wait) begin
          resp_ack = 1'b1;
          dmem_rdata = ack_data;
        end else begin
          resp_ack = 1'b0;
          dmem_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        rcnt = 0;
        resp_ack = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Request monitor: checks request fields, stability and length against req_q.
  initial begin
    req_exp_t    cur;
    logic        active;
    logic        stable;
    int          len;
    logic        we0;
    logic [31:0] addr0, wdata0;
    active = 1'b0;
    stable = 1'b1;
    len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        active = 1'b0;
      end else if (dmem_req && !active) begin
        prev_rise = last_rise;
        last_rise = cyc;
        active = 1'b1;
        stable = 1'b1;
        len = 1;
        we0 = dmem_we;
        addr0 = dmem_addr;
        wdata0 = dmem_wdata;
        if (req_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_req: got addr %h expected no request", dmem_addr);
          cur.len = 0;
        end else begin
          cur = req_q.pop_front();
          chk("req_we", {31'd0, dmem_we}, {31'd0, cur.we});
          chk("req_addr", dmem_addr, cur.addr);
          if (cur.we) chk("req_wdata", dmem_wdata, cur.wdata);
        end
      end else if (dmem_req && active) begin
        len++;
        if (dmem_we !== we0 || dmem_addr !== addr0 || dmem_wdata !== wdata0) stable = 1'b0;
      end else if (!dmem_req && active) begin
        active = 1'b0;
        chk("req_len", len, cur.len);
        chk("req_stable", {31'd0, stable}, 32'd1);
      end
    end
  end

  // Result monitor: a stall falling edge marks DONE; compare against res_q.
  initial begin
    logic     prev_stall;
    res_exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !stall_mem) begin
          if (res_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: got rdata %h expected no result", mem_read_data);
          end else begin
            e = res_q.pop_front();
            chk("res_rdata", mem_read_data, e.rdata);
            chk("res_fault", {31'd0, mem_fault}, {31'd0, e.fault});
          end
        end
        prev_stall = stall_mem;
      end
    end
  end

  task automatic drive_idle();
    @(posedge clk);
    #1;
    mem_read_mem = 1'b0;
    mem_write_mem = 1'b0;
    alu_result_mem = 32'd0;
    read_data2_mem = 32'd0;
  endtask

  // Issue one MEM-stage instruction, hold it while stalled, return at the DONE negedge.
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int wait_c, input logic [31:0] data,
                           input logic [31:0] exp_rd, input logic exp_fault,
                           input int exp_req_len, input int exp_stall);
    req_exp_t r;
    res_exp_t s;
    int n;
    @(posedge clk);
    #1;
    ack_wait = wait_c;
    ack_data = data;
    if (exp_req_len > 0) begin
      r.we = wr;
      r.addr = {addr[31:2], 2'b00};
      r.wdata = wdata;
      r.len = exp_req_len;
      req_q.push_back(r);
    end
    s.rdata = exp_rd;
    s.fault = exp_fault;
    res_q.push_back(s);
    mem_read_mem = rd;
    mem_write_mem = wr;
    alu_result_mem = addr;
    read_data2_mem = wdata;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall_mem) n++;
      else break;
    end
    chk({name, "_stall_cycles"}, n, exp_stall);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    late_ack = 1'b0;
    ack_wait = 0;
    ack_data = 32'd0;
    mem_read_mem = 1'b1;  // access requested during reset must not stall
    mem_write_mem = 1'b0;
    branch_mem = 1'b0;
    zero_mem = 1'b0;
    alu_result_mem = 32'h0000_0010;
    read_data2_mem = 32'd0;
    #2;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_rdata", mem_read_data, 32'd0);
    chk("rst_fault", {31'd0, mem_fault}, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    mem_read_mem = 1'b0;
    alu_result_mem = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Load, ack in first REQ cycle.
    do_access("load10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1, 32'hCAFE_F00D,
              32'hCAFE_F00D, 1'b0, 1, 2);
    drive_idle();
    // Misaligned load: no request, fault, data cleared.
    do_access("misalign", 1'b1, 1'b0, 32'h0000_0013, 32'd0, 1, 32'h1111_1111,
              32'd0, 1'b1, 0, 1);
    drive_idle();
    // Store, ack in 4th REQ cycle.
    do_access("store20", 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4, 32'h5555_5555,
              32'd0, 1'b0, 4, 5);
    drive_idle();
    // Back-to-back loads.
    do_access("load40", 1'b1, 1'b0, 32'h0000_0040, 32'd0, 1, 32'h1111_0040,
              32'h1111_0040, 1'b0, 1, 2);
    do_access("load44", 1'b1, 1'b0, 32'h0000_0044, 32'd0, 1, 32'h2222_0044,
              32'h2222_0044, 1'b0, 1, 2);
    chk("b2b_req_gap", last_rise - prev_rise, 32'd3);
    drive_idle();
    // Timeout: no ack, request lasts 16 cycles.
    do_access("timeout", 1'b1, 1'b0, 32'h0000_0080, 32'd0, 0, 32'd0,
              32'd0, 1'b1, 16, 17);
    drive_idle();
    drive_idle();
    // Late ack while idle must be ignored.
    @(posedge clk);
    #1;
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", mem_read_data, 32'd0);
    chk("late_ack_fault", {31'd0, mem_fault}, 32'd0);
    chk("late_ack_stall", {31'd0, stall_mem}, 32'd0);
    chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
    // Read and write together: performed as a write, faults.
    do_access("rw_both", 1'b1, 1'b1, 32'h0000_0050, 32'hA5A5_A5A5, 2, 32'h7777_7777,
              32'd0, 1'b1, 2, 3);
    drive_idle();

    // Reset in the middle of an outstanding request.
    @(posedge clk);
    #1;
    begin
      req_exp_t r;
      r.we = 1'b0;
      r.addr = 32'h0000_0060;
      r.wdata = 32'd0;
      r.len = 0;
      req_q.push_back(r);
    end
    ack_wait = 0;
    mem_read_mem = 1'b1;
    alu_result_mem = 32'h0000_0060;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("midreq_req_before", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    mem_read_mem = 1'b0;
    alu_result_mem = 32'd0;
    #1;
    chk("midreq_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("midreq_rst_fault", {31'd0, mem_fault}, 32'd0);
    chk("midreq_rst_stall", {31'd0, stall_mem}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_stall", {31'd0, stall_mem}, 32'd0);
      chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
    end

    // Branch resolution.
    @(posedge clk);
    #1;
    branch_mem = 1'b1;
    zero_mem = 1'b1;
    #1;
    chk("pc_src_taken", {31'd0, pc_src}, 32'd1);
    chk("pc_src_nostall", {31'd0, stall_mem}, 32'd0);
    zero_mem = 1'b0;
    #1;
    chk("pc_src_not_taken", {31'd0, pc_src}, 32'd0);
    branch_mem = 1'b0;

    drive_idle();
    drive_idle();
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("res_q_drained", res_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
